// File: rtl/fpu_pkg.sv
// Shared FPU front-end definitions: format widths, FCLASS bit positions,
// decoder state encoding and the FCLASS mask builder.
package fpu_pkg;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;

  localparam int CLASS_W       = 10;
  localparam int CLS_NEG_INF   = 0;
  localparam int CLS_NEG_NORM  = 1;
  localparam int CLS_NEG_SUB   = 2;
  localparam int CLS_NEG_ZERO  = 3;
  localparam int CLS_POS_ZERO  = 4;
  localparam int CLS_POS_SUB   = 5;
  localparam int CLS_POS_NORM  = 6;
  localparam int CLS_POS_INF   = 7;
  localparam int CLS_SNAN      = 8;
  localparam int CLS_QNAN      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } state_t;

  // NaNs ignore the sign; every other class splits on it.
  function automatic logic [CLASS_W-1:0] fclass_mask(
    input logic sign,
    input logic is_inf,
    input logic is_norm,
    input logic is_sub,
    input logic is_zero,
    input logic is_snan,
    input logic is_qnan
  );
    logic [CLASS_W-1:0] m;
    m               = {CLASS_W{1'b0}};
    m[CLS_NEG_INF]  = sign & is_inf;
    m[CLS_NEG_NORM] = sign & is_norm;
    m[CLS_NEG_SUB]  = sign & is_sub;
    m[CLS_NEG_ZERO] = sign & is_zero;
    m[CLS_POS_ZERO] = ~sign & is_zero;
    m[CLS_POS_SUB]  = ~sign & is_sub;
    m[CLS_POS_NORM] = ~sign & is_norm;
    m[CLS_POS_INF]  = ~sign & is_inf;
    m[CLS_SNAN]     = is_snan;
    m[CLS_QNAN]     = is_qnan;
    return m;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/fpu_decoder_norm.sv
// IEEE-754 operand decoder/classifier with iterative subnormal normalisation.
// Subnormals are shifted up to SHIFT_STEP positions per cycle until the
// significand MSB is set; class flags always describe the original operand.
module fpu_decoder_norm
  import fpu_pkg::*;
#(
  parameter int EXP_W      = FP32_EXP_W,
  parameter int FRAC_W     = FP32_FRAC_W,
  parameter int SHIFT_STEP = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [EXP_W+FRAC_W:0] operand_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                sign_o,
  output logic [EXP_W+1:0]    exp_o,
  output logic [FRAC_W:0]     sig_o,
  output logic [CLASS_W-1:0]  class_o,
  output logic                is_zero_o,
  output logic                is_subnormal_o,
  output logic                is_inf_o,
  output logic                is_nan_o,
  output logic                is_signaling_o
);

  localparam int SIG_W = FRAC_W + 1;
  localparam int XW    = EXP_W + 2;
  localparam int CNT_W = $clog2(SIG_W + 1);

  state_t state, state_next;

  logic                    sign;
  logic signed [XW-1:0]    exp_val;
  logic [SIG_W-1:0]        sig;
  logic [CLASS_W-1:0]      cls;
  logic                    f_zero, f_sub, f_inf, f_nan, f_snan;

  // Raw operand fields and classification
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [FRAC_W-1:0] in_frac;
  logic              exp_max, exp_zero, frac_zero;
  logic              d_inf, d_nan, d_snan, d_qnan, d_sub, d_zero, d_norm;
  logic [XW-1:0]     d_exp;
  logic [SIG_W-1:0]  d_sig;

  assign {in_sign, in_exp, in_frac} = operand_i;
  assign exp_max   = &in_exp;
  assign exp_zero  = ~|in_exp;
  assign frac_zero = ~|in_frac;
  assign d_inf     = exp_max & frac_zero;
  assign d_nan     = exp_max & ~frac_zero;
  assign d_snan    = d_nan & ~in_frac[FRAC_W-1];
  assign d_qnan    = d_nan & in_frac[FRAC_W-1];
  assign d_sub     = exp_zero & ~frac_zero;
  assign d_zero    = exp_zero & frac_zero;
  assign d_norm    = ~exp_max & ~exp_zero;
  // Zero and subnormal share the minimum normal exponent of 1.
  assign d_exp     = exp_zero ? {{(XW-1){1'b0}}, 1'b1} : {2'b00, in_exp};
  assign d_sig     = {~exp_zero, in_frac};

  // Per-cycle normalisation step, bounded by SHIFT_STEP
  logic [CNT_W-1:0] lz, k;
  logic [SIG_W-1:0] sig_shift;
  logic [XW-1:0]    exp_shift;

  fpu_lzc #(.WIDTH(SIG_W), .CNT_W(CNT_W)) u_lzc (
    .data  (sig),
    .count (lz)
  );

  assign k         = (lz > CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP) : lz;
  assign sig_shift = sig << k;
  assign exp_shift = exp_val - $signed({{(XW-CNT_W){1'b0}}, k});

  logic accept;
  assign accept = valid_i & ready_o;

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (valid_i) begin
          state_next = d_sub ? NORM : HOLD;
        end else begin
          state_next = IDLE;
        end
      end
      NORM: begin
        if (sig_shift[SIG_W-1]) begin
          state_next = HOLD;
        end else begin
          state_next = NORM;
        end
      end
      HOLD: begin
        if (ready_i) begin
          if (valid_i) begin
            state_next = d_sub ? NORM : HOLD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = HOLD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs derived from state
  always_comb begin
    valid_o = 1'b0;
    ready_o = 1'b0;
    case (state)
      IDLE:    ready_o = 1'b1;
      NORM:    ready_o = 1'b0;
      HOLD: begin
        valid_o = 1'b1;
        ready_o = ready_i;
      end
      default: ready_o = 1'b0;
    endcase
  end

  // Result registers: load decode on accept, shift while normalising
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sign    <= 1'b0;
      exp_val <= {XW{1'b0}};
      sig     <= {SIG_W{1'b0}};
      cls     <= {CLASS_W{1'b0}};
      f_zero  <= 1'b0;
      f_sub   <= 1'b0;
      f_inf   <= 1'b0;
      f_nan   <= 1'b0;
      f_snan  <= 1'b0;
    end else if (accept) begin
      sign    <= in_sign;
      exp_val <= d_exp;
      sig     <= d_sig;
      cls     <= fclass_mask(in_sign, d_inf, d_norm, d_sub, d_zero, d_snan, d_qnan);
      f_zero  <= d_zero;
      f_sub   <= d_sub;
      f_inf   <= d_inf;
      f_nan   <= d_nan;
      f_snan  <= d_snan;
    end else if (state == NORM) begin
      sig     <= sig_shift;
      exp_val <= exp_shift;
    end
  end

  assign sign_o         = sign;
  assign exp_o          = exp_val;
  assign sig_o          = sig;
  assign class_o        = cls;
  assign is_zero_o      = f_zero;
  assign is_subnormal_o = f_sub;
  assign is_inf_o       = f_inf;
  assign is_nan_o       = f_nan;
  assign is_signaling_o = f_snan;

endmodule

// File: tb/tb_fpu_decoder_norm.sv
// Scoreboard bench for fpu_decoder_norm: FP32 instance with random handshakes
// and a directed FP16 / SHIFT_STEP=1 instance.
module tb_fpu_decoder_norm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // FP32 instance
  logic        reset_i, valid_i, ready_o, valid_o, ready_i;
  logic [31:0] operand_i;
  logic        sign_o;
  logic [9:0]  exp_o;
  logic [23:0] sig_o;
  logic [9:0]  class_o;
  logic        is_zero_o, is_subnormal_o, is_inf_o, is_nan_o, is_signaling_o;

  fpu_decoder_norm #(.EXP_W(8), .FRAC_W(23), .SHIFT_STEP(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .operand_i(operand_i), .valid_o(valid_o), .ready_i(ready_i),
    .sign_o(sign_o), .exp_o(exp_o), .sig_o(sig_o), .class_o(class_o),
    .is_zero_o(is_zero_o), .is_subnormal_o(is_subnormal_o), .is_inf_o(is_inf_o),
    .is_nan_o(is_nan_o), .is_signaling_o(is_signaling_o)
  );

  // FP16 instance, one shift per cycle
  logic        h_reset, h_valid, h_ready_o, h_valid_o, h_ready_i;
  logic [15:0] h_op;
  logic        h_sign;
  logic [6:0]  h_exp;
  logic [10:0] h_sig;
  logic [9:0]  h_class;
  logic        h_zero, h_sub, h_inf, h_nan, h_snan;

  fpu_decoder_norm #(.EXP_W(5), .FRAC_W(10), .SHIFT_STEP(1)) dut16 (
    .clk_i(clk), .reset_i(h_reset), .valid_i(h_valid), .ready_o(h_ready_o),
    .operand_i(h_op), .valid_o(h_valid_o), .ready_i(h_ready_i),
    .sign_o(h_sign), .exp_o(h_exp), .sig_o(h_sig), .class_o(h_class),
    .is_zero_o(h_zero), .is_subnormal_o(h_sub), .is_inf_o(h_inf),
    .is_nan_o(h_nan), .is_signaling_o(h_snan)
  );

  typedef struct {
    bit        sign;
    int        exp;
    longint    sig;
    bit [9:0]  cls;
    bit        zero, sub, inf, nan, snan;
    int        lat;
    int        acc;
  } exp_t;

  // Reference: classify by field values, normalise a subnormal by counting
  // leading zeros arithmetically; latency follows from shifts per cycle.
  function automatic exp_t ref_model(input longint op, input int ew, input int fw, input int step);
    exp_t r;
    longint fr, e, emax;
    int lz;
    fr     = op & ((64'd1 << fw) - 1);
    e      = (op >> fw) & ((64'd1 << ew) - 1);
    emax   = (64'd1 << ew) - 1;
    r.sign = ((op >> (ew + fw)) & 1) != 0;
    r.inf  = (e == emax) && (fr == 0);
    r.nan  = (e == emax) && (fr != 0);
    r.snan = r.nan && (((fr >> (fw - 1)) & 1) == 0);
    r.sub  = (e == 0) && (fr != 0);
    r.zero = (e == 0) && (fr == 0);
    r.cls  = '0;
    if (r.nan)       r.cls[r.snan ? 8 : 9] = 1'b1;
    else if (r.inf)  r.cls[r.sign ? 0 : 7] = 1'b1;
    else if (r.zero) r.cls[r.sign ? 3 : 4] = 1'b1;
    else if (r.sub)  r.cls[r.sign ? 2 : 5] = 1'b1;
    else             r.cls[r.sign ? 1 : 6] = 1'b1;
    r.exp = (e == 0) ? 1 : int'(e);
    r.sig = (e == 0) ? fr : ((64'd1 << fw) | fr);
    r.lat = 1;
    r.acc = 0;
    if (r.sub) begin
      lz = 0;
      while (((r.sig >> (fw - lz)) & 1) == 0) lz++;
      r.exp = 1 - lz;
      r.sig = r.sig << lz;
      r.lat = 1 + (lz + step - 1) / step;
    end
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Scoreboard state
  exp_t        sb[$];
  exp_t        mon_e;
  bit          mon_en = 1'b0;
  bit          presented = 1'b0;
  bit          stall = 1'b0;
  logic [49:0] snap;
  wire  [49:0] out_bus = {sign_o, exp_o, sig_o, class_o, is_zero_o, is_subnormal_o,
                          is_inf_o, is_nan_o, is_signaling_o};

  // Monitor: checks handshake, stability under backpressure, latency and data
  always @(negedge clk) begin
    if (mon_en && !reset_i) begin
      chk("ready_o", ready_o, (sb.size() == 0) || (valid_o && ready_i));
      if (stall) begin
        chk("stall_valid", valid_o, 1);
        chk("stall_stable", out_bus, snap);
      end
      stall = valid_o && !ready_i;
      snap  = out_bus;
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", valid_o, 0);
        end else begin
          if (!presented) begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
            presented = 1'b1;
          end
          if (ready_i) begin
            mon_e = sb.pop_front();
            presented = 1'b0;
            chk("sign", sign_o, mon_e.sign);
            chk("exp", longint'($signed(exp_o)), mon_e.exp);
            chk("sig", sig_o, mon_e.sig);
            chk("class", class_o, mon_e.cls);
            chk("flags", {is_zero_o, is_subnormal_o, is_inf_o, is_nan_o, is_signaling_o},
                {mon_e.zero, mon_e.sub, mon_e.inf, mon_e.nan, mon_e.snan});
          end
        end
      end
    end
  end

  // One cycle of FP32 stimulus; pushes the expectation if accepted
  task automatic drive(input bit v, input logic [31:0] op, input bit rdy, output bit acc);
    exp_t x;
    @(posedge clk); #1;
    valid_i = v; operand_i = op; ready_i = rdy;
    @(negedge clk); #1;
    acc = valid_i && ready_o;
    if (acc) begin
      x = ref_model(longint'(op), 8, 23, 4);
      x.acc = cyc;
      sb.push_back(x);
    end
  endtask

  task automatic send(input logic [31:0] op, input bit rand_rdy);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      drive(1'b1, op, rand_rdy ? ($urandom_range(0, 9) < 7) : 1'b1, acc);
      tries++;
    end
    if (!acc) chk("send_accept", 0, 1);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, rdy, acc);
  endtask

  function automatic logic [31:0] rand_fp32();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 5))
      0, 5: e = 8'($urandom_range(1, 254));
      1: begin
        e = 8'h00;
        f = f >> $urandom_range(0, 22);
        if (f == 23'h0) f = 23'h1;
      end
      2: begin e = 8'h00; f = 23'h0; end
      3: begin e = 8'hFF; f = 23'h0; end
      default: begin
        e = 8'hFF;
        if (f == 23'h0) f = 23'h1;
      end
    endcase
    return {s, e, f};
  endfunction

  // FP16 directed check: one operand at a time, ready_i held high
  task automatic h_check(input logic [15:0] op);
    exp_t x;
    int lat;
    x = ref_model(longint'(op), 5, 10, 1);
    @(posedge clk); #1;
    h_valid = 1'b1; h_op = op;
    @(negedge clk);
    chk("h_ready_o", h_ready_o, 1);
    @(posedge clk); #1;
    h_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!h_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("h_latency", lat, x.lat);
    chk("h_sign", h_sign, x.sign);
    chk("h_exp", longint'($signed(h_exp)), x.exp);
    chk("h_sig", h_sig, x.sig);
    chk("h_class", h_class, x.cls);
    chk("h_flags", {h_zero, h_sub, h_inf, h_nan, h_snan},
        {x.zero, x.sub, x.inf, x.nan, x.snan});
  endtask

  logic [31:0] directed [7] = '{32'h3F800000, 32'h00000001, 32'h80400000, 32'h7F800001,
                                32'h7FC00000, 32'hFF800000, 32'h80000000};

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; operand_i = 32'h0;
    h_reset = 1'b1; h_valid = 1'b0; h_ready_i = 1'b1; h_op = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0; h_reset = 1'b0;
    @(negedge clk);
    chk("reset_valid_o", valid_o, 0);
    chk("reset_outputs", out_bus, 0);
    chk("reset_ready_o", ready_o, 1);
    mon_en = 1'b1;

    // Directed operands from the reference cases
    foreach (directed[i]) send(directed[i], 1'b0);
    idle(10, 1'b1);

    // Backpressure: hold a result for several cycles
    send(32'h3F800000, 1'b0);
    idle(6, 1'b0);
    idle(3, 1'b1);

    // Back-to-back normals at full rate
    for (int i = 0; i < 8; i++) send({1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)}, 1'b0);
    idle(3, 1'b1);

    // Reset while normalising a subnormal
    send(32'h00000001, 1'b0);
    idle(2, 1'b1);
    @(posedge clk); #1;
    reset_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b0;
    sb.delete();
    presented = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("norm_reset_valid_o", valid_o, 0);
    chk("norm_reset_outputs", out_bus, 0);
    chk("norm_reset_ready_o", ready_o, 1);
    send(32'h40000000, 1'b0);
    idle(3, 1'b1);

    // Random traffic with random handshakes on both sides
    for (int i = 0; i < 300; i++) begin
      bit acc;
      if ($urandom_range(0, 9) < 8) send(rand_fp32(), 1'b1);
      else drive(1'b0, 32'h0, 1'($urandom_range(0, 1)), acc);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1, 1'b1);
    chk("drain", sb.size(), 0);

    // FP16, SHIFT_STEP=1
    h_check(16'h0001);
    h_check(16'h8200);
    h_check(16'h7C01);
    h_check(16'h3C00);
    for (int i = 0; i < 20; i++) h_check(16'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
